uart_rx: RTL and testbench

UART receiver for 8N1 serial frames, LSB first, at a fixed baud set by a clock-divider parameter. It is the receive counterpart to the team's UART transmitter and shares its `CLOCK_DIV` convention, so one value configures both ends of a link. It synchronizes the asynchronous `rx` line, validates the start bit at mid-bit, samples each data bit at its centre, and checks the stop bit. Each good byte is presented with a one-cycle strobe; each bad stop bit raises a one-cycle error strobe.

---
 rtl/uart_rx.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, CLOCK_DIV clocks per bit.
// A frame is validated at mid start bit, each data bit is sampled at its
// centre, and the stop bit is checked at its centre. Good bytes produce a
// one-cycle valid strobe; a low stop bit produces a one-cycle frame_error.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | line idle, waiting for a low rx_s (start edge)
//  START     | counting to mid start bit to confirm it is still low
//  DATA      | sampling 8 data bits, one every CLOCK_DIV cycles
//  STOP      | counting to mid stop bit, then checking it is high
//  WAIT_HIGH | stop bit was low; hold off until the line returns high

module uart_rx #(
    parameter int CLOCK_DIV = 1250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_error,
    output logic       busy
);

    // Counter compare points, sized to the 16-bit clock counter.
    localparam logic [15:0] DIV_M1  = 16'(CLOCK_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'((CLOCK_DIV / 2) - 1);

    // A divider below 4 leaves no room between the half-bit and full-bit
    // compare points, so refuse to elaborate.
    if (CLOCK_DIV < 4 || CLOCK_DIV > 65535) begin : g_bad_div
        $error("uart_rx: CLOCK_DIV must be in 4..65535");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        rx_meta;
    logic        rx_s;

    logic [15:0] clock_count;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;

    logic        half_tick;
    logic        bit_tick;

    logic        valid_nxt;
    logic        frame_error_nxt;
    logic        load_data;

    assign half_tick = (clock_count == HALF_M1);
    assign bit_tick  = (clock_count == DIV_M1);

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (half_tick) begin
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick && (bit_idx == 3'd7)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_nxt = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode: strobe requests at the stop sample, busy from state.
    always_comb begin
        valid_nxt       = 1'b0;
        frame_error_nxt = 1'b0;
        load_data       = 1'b0;
        busy            = (state != IDLE);
        if ((state == STOP) && bit_tick) begin
            if (rx_s) begin
                valid_nxt = 1'b1;
                load_data = 1'b1;
            end else begin
                frame_error_nxt = 1'b1;
            end
        end
    end

    // Bit timing counter, bit index and data shifter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clock_count <= 16'd0;
            bit_idx     <= 3'd0;
            shift_reg   <= 8'h00;
        end else begin
            case (state)
                START: begin
                    if (half_tick) begin
                        clock_count <= 16'd0;
                        bit_idx     <= 3'd0;
                    end else begin
                        clock_count <= clock_count + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_reg   <= {rx_s, shift_reg[7:1]};
                        clock_count <= 16'd0;
                        bit_idx     <= bit_idx + 3'd1;
                    end else begin
                        clock_count <= clock_count + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        clock_count <= 16'd0;
                    end else begin
                        clock_count <= clock_count + 16'd1;
                    end
                end
                default: begin
                    clock_count <= 16'd0;
                end
            endcase
        end
    end

    // Registered strobes and the held output byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out    <= 8'h00;
            valid       <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            valid       <= valid_nxt;
            frame_error <= frame_error_nxt;
            if (load_data) begin
                data_out <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at CLOCK_DIV = 16.
// Expected frames are queued as they are driven and checked on each strobe.

module tb_uart_rx;

    localparam int DIV = 16;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } sb_entry_t;

    logic       clock;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_error;
    logic       busy;

    int         n_checks;
    int         n_fail;
    int         cyc;
    int         valid_cnt;
    int         ferr_cnt;
    int         busy_run;
    int         last_busy_len;
    logic       prev_busy;
    logic       prev_strobe;
    logic [7:0] last_good;
    sb_entry_t  sb[$];
    int         valid_times[$];

    uart_rx #(.CLOCK_DIV(DIV)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .data_out    (data_out),
        .valid       (valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, actual, actual, expected, expected, cyc);
        end
    endtask

    // Strobe monitor and scoreboard consumer.
    always @(negedge clock) begin
        sb_entry_t e;
        cyc++;
        if (valid || frame_error) begin
            check("strobe_exclusive", int'(valid & frame_error), 0);
            check("strobe_gap", int'(prev_strobe), 0);
            check("sb_nonempty", int'(sb.size() > 0), 1);
        end
        if (valid) begin
            valid_cnt++;
            valid_times.push_back(cyc);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("valid_kind", 0, int'(e.is_err));
                check("data_out", int'(data_out), int'(e.data));
                last_good = e.data;
            end
        end
        if (frame_error) begin
            ferr_cnt++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ferr_kind", 1, int'(e.is_err));
                check("ferr_data_hold", int'(data_out), int'(last_good));
            end
        end
        prev_strobe = valid | frame_error;
        if (busy) begin
            busy_run++;
        end else if (prev_busy) begin
            last_busy_len = busy_run;
            busy_run      = 0;
        end
        prev_busy = busy;
    end

    task automatic drive_level(input logic level, input int cycles);
        rx = level;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int bitlen);
        drive_level(1'b0, bitlen);
        for (int k = 0; k < 8; k++) begin
            drive_level(d[k], bitlen);
        end
        drive_level(stop, bitlen);
        rx = 1'b1;
    endtask

    task automatic expect_good(input logic [7:0] d);
        sb_entry_t e;
        e.is_err = 1'b0;
        e.data   = d;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, int'(data_out), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_frame_error"}, int'(frame_error), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    // Send one good byte and check strobe count, data and busy length.
    task automatic good_frame(input logic [7:0] d, input int bitlen, input string tag);
        int v0;
        int f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        expect_good(d);
        send_byte(d, 1'b1, bitlen);
        drive_level(1'b1, 12);
        check({tag, "_valid_cnt"}, valid_cnt - v0, 1);
        check({tag, "_ferr_cnt"}, ferr_cnt - f0, 0);
        check({tag, "_data"}, int'(data_out), int'(d));
        check({tag, "_busy_idle"}, int'(busy), 0);
    endtask

    initial begin
        int v0;
        int f0;
        int n;
        int idx0;
        sb_entry_t e;

        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        valid_cnt     = 0;
        ferr_cnt      = 0;
        busy_run      = 0;
        last_busy_len = 0;
        prev_busy     = 1'b0;
        prev_strobe   = 1'b0;
        last_good     = 8'h00;
        rx            = 1'b1;
        reset         = 1'b1;

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        drive_level(1'b1, 10);

        // Single good frames with exact busy width.
        good_frame(8'h55, DIV, "f55");
        check("f55_busy_len", last_busy_len, DIV / 2 + 9 * DIV);
        good_frame(8'hA5, DIV, "fA5");
        check("fA5_busy_len", last_busy_len, DIV / 2 + 9 * DIV);

        // Short low glitch: rejected at the mid-start check.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        drive_level(1'b0, 3);
        drive_level(1'b1, 20);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_busy_len", last_busy_len, DIV / 2);
        check("glitch_busy", int'(busy), 0);

        // Bad stop bit followed by a held-low line.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        e.is_err = 1'b1;
        e.data   = 8'h3C;
        sb.push_back(e);
        send_byte(8'h3C, 1'b0, DIV);
        drive_level(1'b0, 100 - DIV);
        check("break_ferr_cnt", ferr_cnt - f0, 1);
        check("break_valid_cnt", valid_cnt - v0, 0);
        check("break_data_hold", int'(data_out), 8'hA5);
        check("break_busy", int'(busy), 1);
        rx = 1'b1;
        n  = 0;
        while (busy && n < 10) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("break_busy_clear_2to3", int'(n >= 2 && n <= 3), 1);
        drive_level(1'b1, 10);
        check("break_ferr_total", ferr_cnt - f0, 1);
        good_frame(8'h81, DIV, "f81");

        // Back-to-back frames, no idle gap.
        idx0 = valid_times.size();
        expect_good(8'h00);
        expect_good(8'hFF);
        expect_good(8'h7E);
        send_byte(8'h00, 1'b1, DIV);
        send_byte(8'hFF, 1'b1, DIV);
        send_byte(8'h7E, 1'b1, DIV);
        drive_level(1'b1, 12);
        check("b2b_valid_cnt", valid_times.size() - idx0, 3);
        if (valid_times.size() >= idx0 + 3) begin
            check("b2b_gap1", valid_times[idx0 + 1] - valid_times[idx0], 10 * DIV);
            check("b2b_gap2", valid_times[idx0 + 2] - valid_times[idx0 + 1], 10 * DIV);
        end
        check("b2b_last_data", int'(data_out), 8'h7E);

        // Reset during bit 4 of 0x12.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        drive_level(1'b0, DIV);
        for (int k = 0; k < 4; k++) begin
            drive_level(1'(8'h12 >> k), DIV);
        end
        drive_level(1'(8'h12 >> 4), DIV / 2);
        check("midrst_busy_before", int'(busy), 1);
        reset = 1'b1;
        rx    = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clock);
        reset     = 1'b0;
        last_good = 8'h00;
        drive_level(1'b1, 2 * DIV);
        check("midrst_no_valid", valid_cnt - v0, 0);
        check("midrst_no_ferr", ferr_cnt - f0, 0);
        good_frame(8'h34, DIV, "f34");

        // Baud skew in both directions.
        good_frame(8'hC3, DIV - 1, "skew15");
        good_frame(8'hC3, DIV + 1, "skew17");

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
